// File: rtl/store_pulse_gen_pkg.sv
// Shared definitions for the push-button store strobe generator: FSM state
// encoding, default debounce/count sizing and small helper functions used by
// the generator and by board-level tops that instantiate it.
package store_pulse_gen_pkg;

  // Default number of consecutive stable synchronized samples to accept a level change.
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 32'd4;

  // Default width of the accepted-press counter.
  localparam int unsigned COUNT_WIDTH_DEFAULT = 32'd8;

  // Debounce FSM states; held is asserted in the two upper states.
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

  // Width of the debounce counter: just enough bits to hold DEBOUNCE_CYCLES-1.
  function automatic int unsigned debounce_cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles);
    if (w < 32'd1) begin
      w = 32'd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  // The debounced level is high once a press has been accepted and until the
  // release has been confirmed.
  function automatic logic state_is_held(input btn_state_e st);
    logic h;
    case (st)
      ST_PRESSED:      h = 1'b1;
      ST_RELEASE_WAIT: h = 1'b1;
      ST_IDLE:         h = 1'b0;
      ST_PRESS_WAIT:   h = 1'b0;
      default:         h = 1'b0;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/store_pulse_gen_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs (push buttons, slide
// switches). The first stage may go metastable; only the second stage output
// is to be used by downstream logic.
module sync_2ff #(
  parameter int unsigned WIDTH = 32'd1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  // Two back-to-back sampling stages, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= {WIDTH{1'b0}};
      s2_q <= {WIDTH{1'b0}};
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/store_pulse_gen.sv
// Push-button store strobe generator. The raw button level is synchronized,
// debounced by a four-state FSM with a shared sample counter, and turned into
// a single-cycle store strobe per accepted press. The debounced level and a
// wrapping count of accepted presses are also exported. All outputs are
// registered; the raw input only reaches the synchronizer.
module store_pulse_gen
  import store_pulse_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned COUNT_WIDTH     = COUNT_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_raw,
  output logic                   store,
  output logic                   held,
  output logic [COUNT_WIDTH-1:0] press_count
);

  localparam int unsigned CNT_W = debounce_cnt_width(DEBOUNCE_CYCLES);

  // Last counter value before the level change is accepted; the counter
  // starts at 1 on the first differing sample, so DEBOUNCE_CYCLES-1 marks
  // that the current sample is the DEBOUNCE_CYCLES-th consecutive one.
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  localparam logic [COUNT_WIDTH-1:0] PRESS_ONE  = COUNT_WIDTH'(1'b1);
  localparam logic [COUNT_WIDTH-1:0] PRESS_ZERO = {COUNT_WIDTH{1'b0}};

  logic                   btn_sync_s;

  btn_state_e             state_q;
  btn_state_e             state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   store_q;
  logic                   store_d;
  logic                   held_q;
  logic                   held_d;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;

  sync_2ff #(
    .WIDTH (32'd1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (btn_raw),
    .q_o   (btn_sync_s)
  );

  // Debounce FSM next state and counter; the >= compare keeps the counter
  // from ever running past CNT_MAX even from a corrupted value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (btn_sync_s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      ST_PRESS_WAIT: begin
        if (btn_sync_s) begin
          if (cnt_q >= CNT_MAX) begin
            state_d = ST_PRESSED;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_PRESS_WAIT;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      ST_PRESSED: begin
        if (!btn_sync_s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = ST_PRESSED;
          cnt_d   = CNT_ZERO;
        end
      end
      ST_RELEASE_WAIT: begin
        if (!btn_sync_s) begin
          if (cnt_q >= CNT_MAX) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_RELEASE_WAIT;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else begin
          // Bounce during release: back to pressed without a new strobe.
          state_d = ST_PRESSED;
          cnt_d   = CNT_ZERO;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output next values: strobe only on an accepted press, level follows the
  // next state, count steps together with the strobe.
  always_comb begin
    store_d = 1'b0;
    held_d  = 1'b0;
    count_d = count_q;
    if ((state_q == ST_PRESS_WAIT) && (state_d == ST_PRESSED)) begin
      store_d = 1'b1;
      count_d = count_q + PRESS_ONE;
    end else begin
      store_d = 1'b0;
      count_d = count_q;
    end
    held_d = state_is_held(state_d);
  end

  // State, counter and output registers; reset overrides any in-flight
  // debounce or pending strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      store_q <= 1'b0;
      held_q  <= 1'b0;
      count_q <= PRESS_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
      held_q  <= held_d;
      count_q <= count_d;
    end
  end

  assign store       = store_q;
  assign held        = held_q;
  assign press_count = count_q;

endmodule
